// File: rtl/uart_pkg.sv
// Shared opcodes, parser states and header record for the UART command parser.
package uart_pkg;

   localparam logic [7:0] OP_ECHO = 8'hEC;
   localparam logic [7:0] OP_ADD  = 8'hA0;
   localparam logic [7:0] OP_MUL  = 8'hA1;
   localparam logic [7:0] OP_DIV  = 8'hA2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RSVD,
      ST_LEN_LO,
      ST_LEN_HI,
      ST_ECHO,
      ST_PACK,
      ST_DROP
   } state_e;

   typedef struct packed {
      logic [7:0]  opcode;
      logic [15:0] len;
   } hdr_t;

   function automatic logic op_known(input logic [7:0] op);
      return (op == OP_ECHO) || (op == OP_ADD) || (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/uart_word_packer.sv
// Packs a byte stream into little-endian 32-bit words; a flagged final byte flushes
// a partial word with zero upper bytes.
module uart_word_packer
   import uart_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [7:0]  byte_i,
   input  logic        byte_valid_i,
   input  logic        byte_last_i,
   output logic [31:0] word_o,
   output logic        valid_o,
   output logic        first_o,
   output logic        last_o,
   input  logic        ready_i,
   output logic        ready_o
);

   logic [23:0] acc_q, acc_d;
   logic [1:0]  idx_q, idx_d;
   logic        first_q, first_d;
   logic [31:0] word_q, word_d;
   logic        valid_q, valid_d;
   logic        wfirst_q, wfirst_d;
   logic        wlast_q, wlast_d;
   logic [31:0] merged;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         acc_q    <= '0;
         idx_q    <= '0;
         first_q  <= 1'b0;
         word_q   <= '0;
         valid_q  <= 1'b0;
         wfirst_q <= 1'b0;
         wlast_q  <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         idx_q    <= idx_d;
         first_q  <= first_d;
         word_q   <= word_d;
         valid_q  <= valid_d;
         wfirst_q <= wfirst_d;
         wlast_q  <= wlast_d;
      end
   end

   always_comb begin
      merged   = {8'h00, acc_q};
      acc_d    = acc_q;
      idx_d    = idx_q;
      first_d  = first_q;
      word_d   = word_q;
      valid_d  = valid_q && !ready_i;
      wfirst_d = wfirst_q;
      wlast_d  = wlast_q;
      case (idx_q)
         2'd0:    merged[7:0]   = byte_i;
         2'd1:    merged[15:8]  = byte_i;
         2'd2:    merged[23:16] = byte_i;
         default: merged[31:24] = byte_i;
      endcase
      if (start_i) begin
         acc_d   = '0;
         idx_d   = '0;
         first_d = 1'b1;
      end else if (byte_valid_i) begin
         // Accumulator is cleared on every emit, so a flushed partial word has zero upper bytes.
         if (idx_q == 2'd3 || byte_last_i) begin
            word_d   = merged;
            valid_d  = 1'b1;
            wfirst_d = first_q;
            wlast_d  = byte_last_i;
            first_d  = 1'b0;
            acc_d    = '0;
            idx_d    = '0;
         end else begin
            acc_d = merged[23:0];
            idx_d = idx_q + 2'd1;
         end
      end
   end

   assign word_o  = word_q;
   assign valid_o = valid_q;
   assign first_o = wfirst_q;
   assign last_o  = wlast_q;
   assign ready_o = !valid_q || ready_i;

endmodule

// File: rtl/uart_packet_parser.sv
// Decodes UART command packets (opcode, reserved, len LE) and routes payload to the
// echo register, the operand packer, or discards it.
module uart_packet_parser
   import uart_pkg::*;
#(
   parameter logic [15:0] MAX_LEN = 16'hFFFF
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [7:0]  rx_data_i,
   input  logic        rx_valid_i,
   output logic        rx_ready_o,
   output logic        hdr_valid_o,
   output logic [7:0]  opcode_o,
   output logic [15:0] len_o,
   output logic [7:0]  echo_data_o,
   output logic        echo_valid_o,
   input  logic        echo_ready_i,
   output logic [31:0] opnd_data_o,
   output logic        opnd_valid_o,
   output logic        opnd_first_o,
   output logic        opnd_last_o,
   input  logic        opnd_ready_i,
   output logic        err_o
);

   state_e      state_q, state_d;
   hdr_t        hdr_q, hdr_d;
   logic [7:0]  op_tmp_q, op_tmp_d;
   logic [7:0]  len_lo_q, len_lo_d;
   logic [15:0] cnt_q, cnt_d;
   logic        hdr_valid_q, hdr_valid_d;
   logic        err_q, err_d;
   logic [7:0]  echo_data_q, echo_data_d;
   logic        echo_valid_q, echo_valid_d;
   logic        rx_rdy, pk_start, pk_valid, pk_last, pk_ready;
   logic [15:0] hdr_len;
   logic        hdr_bad;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         hdr_q        <= '0;
         op_tmp_q     <= '0;
         len_lo_q     <= '0;
         cnt_q        <= '0;
         hdr_valid_q  <= 1'b0;
         err_q        <= 1'b0;
         echo_data_q  <= '0;
         echo_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         hdr_q        <= hdr_d;
         op_tmp_q     <= op_tmp_d;
         len_lo_q     <= len_lo_d;
         cnt_q        <= cnt_d;
         hdr_valid_q  <= hdr_valid_d;
         err_q        <= err_d;
         echo_data_q  <= echo_data_d;
         echo_valid_q <= echo_valid_d;
      end
   end

   assign hdr_len = {rx_data_i, len_lo_q};
   assign hdr_bad = !op_known(op_tmp_q) || ({1'b0, hdr_len} > {1'b0, MAX_LEN});

   always_comb begin
      state_d      = state_q;
      hdr_d        = hdr_q;
      op_tmp_d     = op_tmp_q;
      len_lo_d     = len_lo_q;
      cnt_d        = cnt_q;
      hdr_valid_d  = 1'b0;
      err_d        = 1'b0;
      echo_data_d  = echo_data_q;
      echo_valid_d = echo_valid_q && !echo_ready_i;
      rx_rdy       = 1'b0;
      pk_start     = 1'b0;
      pk_valid     = 1'b0;
      pk_last      = (cnt_q == 16'd1);
      case (state_q)
         ST_IDLE: begin
            rx_rdy = 1'b1;
            if (rx_valid_i) begin
               op_tmp_d = rx_data_i;
               state_d  = ST_RSVD;
            end
         end
         ST_RSVD: begin
            rx_rdy = 1'b1;
            if (rx_valid_i) state_d = ST_LEN_LO;
         end
         ST_LEN_LO: begin
            rx_rdy = 1'b1;
            if (rx_valid_i) begin
               len_lo_d = rx_data_i;
               state_d  = ST_LEN_HI;
            end
         end
         ST_LEN_HI: begin
            rx_rdy = 1'b1;
            if (rx_valid_i) begin
               hdr_d       = '{opcode: op_tmp_q, len: hdr_len};
               hdr_valid_d = 1'b1;
               err_d       = hdr_bad;
               cnt_d       = hdr_len;
               if (hdr_len == 16'd0)       state_d = ST_IDLE;
               else if (hdr_bad)           state_d = ST_DROP;
               else if (op_tmp_q == OP_ECHO) state_d = ST_ECHO;
               else begin
                  state_d  = ST_PACK;
                  pk_start = 1'b1;
               end
            end
         end
         ST_ECHO: begin
            // Stay here after the last byte until the echo register has drained.
            rx_rdy = (cnt_q != 16'd0) && (!echo_valid_q || echo_ready_i);
            if (rx_valid_i && rx_rdy) begin
               echo_data_d  = rx_data_i;
               echo_valid_d = 1'b1;
               cnt_d        = cnt_q - 16'd1;
            end else if (cnt_q == 16'd0 && (!echo_valid_q || echo_ready_i)) begin
               state_d = ST_IDLE;
            end
         end
         ST_PACK: begin
            rx_rdy   = (cnt_q != 16'd0) && pk_ready;
            pk_valid = rx_valid_i && rx_rdy;
            if (pk_valid) cnt_d = cnt_q - 16'd1;
            else if (cnt_q == 16'd0 && pk_ready) state_d = ST_IDLE;
         end
         ST_DROP: begin
            rx_rdy = 1'b1;
            if (rx_valid_i) begin
               cnt_d = cnt_q - 16'd1;
               if (cnt_q == 16'd1) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   uart_word_packer u_packer (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .start_i      (pk_start),
      .byte_i       (rx_data_i),
      .byte_valid_i (pk_valid),
      .byte_last_i  (pk_last),
      .word_o       (opnd_data_o),
      .valid_o      (opnd_valid_o),
      .first_o      (opnd_first_o),
      .last_o       (opnd_last_o),
      .ready_i      (opnd_ready_i),
      .ready_o      (pk_ready)
   );

   assign rx_ready_o   = rx_rdy && !rst_i;
   assign hdr_valid_o  = hdr_valid_q;
   assign opcode_o     = hdr_q.opcode;
   assign len_o        = hdr_q.len;
   assign echo_data_o  = echo_data_q;
   assign echo_valid_o = echo_valid_q;
   assign err_o        = err_q;

endmodule

// File: tb/tb_uart_packet_parser.sv
// Directed bench for uart_packet_parser: byte-stream driver, negedge output monitors,
// one task per scenario with hand-computed expectations.
module tb_uart_packet_parser;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [7:0]  rx_data_i;
   logic        rx_valid_i;
   logic        rx_ready_o;
   logic        hdr_valid_o;
   logic [7:0]  opcode_o;
   logic [15:0] len_o;
   logic [7:0]  echo_data_o;
   logic        echo_valid_o;
   logic        echo_ready_i;
   logic [31:0] opnd_data_o;
   logic        opnd_valid_o;
   logic        opnd_first_o;
   logic        opnd_last_o;
   logic        opnd_ready_i;
   logic        err_o;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0]  echo_q[$];
   logic [33:0] opnd_q[$];
   logic [7:0]  tx_q[$];
   int          hdr_cnt, err_cnt;
   logic [7:0]  last_op;
   logic [15:0] last_len;
   logic        echo_hold, opnd_hold;
   logic [7:0]  echo_prev;
   logic [31:0] opnd_prev;

   always #5 clk_i = ~clk_i;

   uart_packet_parser dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .rx_data_i    (rx_data_i),
      .rx_valid_i   (rx_valid_i),
      .rx_ready_o   (rx_ready_o),
      .hdr_valid_o  (hdr_valid_o),
      .opcode_o     (opcode_o),
      .len_o        (len_o),
      .echo_data_o  (echo_data_o),
      .echo_valid_o (echo_valid_o),
      .echo_ready_i (echo_ready_i),
      .opnd_data_o  (opnd_data_o),
      .opnd_valid_o (opnd_valid_o),
      .opnd_first_o (opnd_first_o),
      .opnd_last_o  (opnd_last_o),
      .opnd_ready_i (opnd_ready_i),
      .err_o        (err_o)
   );

   // Inputs change at posedge+1, so negedge values are exactly what the next edge sees.
   always @(negedge clk_i) begin
      if (rst_i) begin
         echo_hold = 1'b0;
         opnd_hold = 1'b0;
      end else begin
         if (echo_valid_o && echo_ready_i) echo_q.push_back(echo_data_o);
         if (opnd_valid_o && opnd_ready_i) opnd_q.push_back({opnd_first_o, opnd_last_o, opnd_data_o});
         if (hdr_valid_o) begin
            hdr_cnt++;
            last_op  = opcode_o;
            last_len = len_o;
         end
         if (err_o) err_cnt++;
         if (echo_hold) begin
            vectors++;
            if (!echo_valid_o || echo_data_o !== echo_prev) begin
               miscompares++;
               $display("FAIL echo_hold: valid=%b data=%h, required valid=1 data=%h", echo_valid_o, echo_data_o, echo_prev);
            end
         end
         if (opnd_hold) begin
            vectors++;
            if (!opnd_valid_o || opnd_data_o !== opnd_prev) begin
               miscompares++;
               $display("FAIL opnd_hold: valid=%b data=%h, required valid=1 data=%h", opnd_valid_o, opnd_data_o, opnd_prev);
            end
         end
         echo_hold = echo_valid_o && !echo_ready_i;
         echo_prev = echo_data_o;
         opnd_hold = opnd_valid_o && !opnd_ready_i;
         opnd_prev = opnd_data_o;
      end
   end

   task automatic clear_obs();
      echo_q.delete();
      opnd_q.delete();
      hdr_cnt = 0;
      err_cnt = 0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      rx_data_i  = b;
      rx_valid_i = 1'b1;
      @(negedge clk_i);
      while (!rx_ready_o && n < 200) begin
         n++;
         @(negedge clk_i);
      end
      if (!rx_ready_o) begin
         vectors++;
         miscompares++;
         $display("FAIL send_byte: byte %h not accepted after %0d cycles", b, n);
      end
      @(posedge clk_i);
      #1;
      rx_valid_i = 1'b0;
   endtask

   task automatic send_tx();
      foreach (tx_q[i]) send_byte(tx_q[i]);
   endtask

   task automatic settle();
      repeat (10) @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      repeat (3) @(negedge clk_i);
      vectors += 6;
      if (rx_ready_o !== 1'b0) begin miscompares++; $display("FAIL rst_rx_ready: got %b want 0", rx_ready_o); end
      if (hdr_valid_o !== 1'b0) begin miscompares++; $display("FAIL rst_hdr_valid: got %b want 0", hdr_valid_o); end
      if (opcode_o !== 8'h00) begin miscompares++; $display("FAIL rst_opcode: got %h want 00", opcode_o); end
      if (len_o !== 16'h0000) begin miscompares++; $display("FAIL rst_len: got %h want 0000", len_o); end
      if ({echo_valid_o, opnd_valid_o, err_o} !== 3'b000) begin
         miscompares++; $display("FAIL rst_valids: got %b want 000", {echo_valid_o, opnd_valid_o, err_o});
      end
      if ({echo_data_o, opnd_data_o} !== 40'h0) begin
         miscompares++; $display("FAIL rst_data: got %h want 0", {echo_data_o, opnd_data_o});
      end
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      @(negedge clk_i);
      vectors++;
      if (rx_ready_o !== 1'b1) begin miscompares++; $display("FAIL idle_rx_ready: got %b want 1", rx_ready_o); end
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_echo();
      clear_obs();
      tx_q = '{8'hec, 8'h00, 8'h02, 8'h00, 8'h5a, 8'ha5};
      send_tx();
      settle();
      vectors += 7;
      if (hdr_cnt !== 1) begin miscompares++; $display("FAIL echo_hdr_cnt: got %0d want 1", hdr_cnt); end
      if ({last_op, last_len} !== {8'hec, 16'h0002}) begin
         miscompares++; $display("FAIL echo_hdr: got %h/%h want ec/0002", last_op, last_len);
      end
      if (echo_q.size() !== 2) begin miscompares++; $display("FAIL echo_count: got %0d want 2", echo_q.size()); end
      if (echo_q.size() > 1 && {echo_q[0], echo_q[1]} !== 16'h5aa5) begin
         miscompares++; $display("FAIL echo_data: got %h %h want 5a a5", echo_q[0], echo_q[1]);
      end
      if (opnd_q.size() !== 0) begin miscompares++; $display("FAIL echo_no_opnd: got %0d want 0", opnd_q.size()); end
      if (err_cnt !== 0) begin miscompares++; $display("FAIL echo_err: got %0d want 0", err_cnt); end
      if ({opcode_o, len_o} !== {8'hec, 16'h0002}) begin
         miscompares++; $display("FAIL echo_hdr_held: got %h/%h want ec/0002", opcode_o, len_o);
      end
   endtask

   task automatic test_add();
      clear_obs();
      tx_q = '{8'ha0, 8'h00, 8'h08, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40};
      send_tx();
      settle();
      vectors += 4;
      if (opnd_q.size() !== 2) begin miscompares++; $display("FAIL add_count: got %0d want 2", opnd_q.size()); end
      if (opnd_q.size() > 0 && opnd_q[0] !== {2'b10, 32'h04030201}) begin
         miscompares++; $display("FAIL add_word0: got %h want 2_04030201", opnd_q[0]);
      end
      if (opnd_q.size() > 1 && opnd_q[1] !== {2'b01, 32'h40302010}) begin
         miscompares++; $display("FAIL add_word1: got %h want 1_40302010", opnd_q[1]);
      end
      if (echo_q.size() !== 0 || {last_op, last_len} !== {8'ha0, 16'h0008}) begin
         miscompares++; $display("FAIL add_misc: echo=%0d hdr=%h/%h want 0 a0/0008", echo_q.size(), last_op, last_len);
      end
   endtask

   task automatic test_mul_partial();
      clear_obs();
      tx_q = '{8'ha1, 8'h00, 8'h06, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
               8'ha2, 8'h00, 8'h03, 8'h00, 8'h01, 8'h02, 8'h03};
      send_tx();
      settle();
      vectors += 4;
      if (opnd_q.size() !== 3) begin miscompares++; $display("FAIL mul_count: got %0d want 3", opnd_q.size()); end
      if (opnd_q.size() > 0 && opnd_q[0] !== {2'b10, 32'h44332211}) begin
         miscompares++; $display("FAIL mul_word0: got %h want 2_44332211", opnd_q[0]);
      end
      if (opnd_q.size() > 1 && opnd_q[1] !== {2'b01, 32'h00006655}) begin
         miscompares++; $display("FAIL mul_word1: got %h want 1_00006655", opnd_q[1]);
      end
      if (opnd_q.size() > 2 && opnd_q[2] !== {2'b11, 32'h00030201}) begin
         miscompares++; $display("FAIL div_single: got %h want 3_00030201", opnd_q[2]);
      end
   endtask

   task automatic test_err_drop();
      clear_obs();
      tx_q = '{8'hff, 8'h00, 8'h03, 8'h00, 8'haa, 8'hbb, 8'hcc, 8'hec, 8'h00, 8'h01, 8'h00, 8'h7e};
      send_tx();
      settle();
      vectors += 4;
      if (err_cnt !== 1) begin miscompares++; $display("FAIL err_count: got %0d want 1", err_cnt); end
      if (hdr_cnt !== 2) begin miscompares++; $display("FAIL err_hdr_cnt: got %0d want 2", hdr_cnt); end
      if (echo_q.size() !== 1 || echo_q[0] !== 8'h7e) begin
         miscompares++; $display("FAIL err_echo: got n=%0d first=%h want n=1 7e", echo_q.size(), echo_q[0]);
      end
      if (opnd_q.size() !== 0) begin miscompares++; $display("FAIL err_no_opnd: got %0d want 0", opnd_q.size()); end
   endtask

   task automatic test_zero_len();
      clear_obs();
      tx_q = '{8'ha0, 8'h00, 8'h00, 8'h00, 8'hec, 8'h00, 8'h01, 8'h00, 8'h44};
      send_tx();
      settle();
      vectors += 3;
      if (hdr_cnt !== 2 || err_cnt !== 0) begin
         miscompares++; $display("FAIL zero_hdr: got hdr=%0d err=%0d want 2 0", hdr_cnt, err_cnt);
      end
      if (opnd_q.size() !== 0) begin miscompares++; $display("FAIL zero_no_opnd: got %0d want 0", opnd_q.size()); end
      if (echo_q.size() !== 1 || echo_q[0] !== 8'h44) begin
         miscompares++; $display("FAIL zero_echo: got n=%0d first=%h want n=1 44", echo_q.size(), echo_q[0]);
      end
   endtask

   task automatic test_stall();
      int n;
      logic stall_ok;
      clear_obs();
      // Echo path stall.
      echo_ready_i = 1'b0;
      tx_q = '{8'hec, 8'h00, 8'h04, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
      fork
         send_tx();
         begin
            n = 0;
            @(negedge clk_i);
            while (!echo_valid_o && n < 100) begin n++; @(negedge clk_i); end
            stall_ok = echo_valid_o;
            for (int i = 0; i < 5; i++) begin
               if (rx_ready_o !== 1'b0) stall_ok = 1'b0;
               @(negedge clk_i);
            end
            vectors++;
            if (!stall_ok) begin miscompares++; $display("FAIL echo_stall: rx_ready not held low (or no echo), want low"); end
            @(posedge clk_i);
            #1;
            echo_ready_i = 1'b1;
         end
      join
      settle();
      vectors++;
      if (echo_q.size() !== 4 || {echo_q[0], echo_q[1], echo_q[2], echo_q[3]} !== 32'h01020304) begin
         miscompares++; $display("FAIL echo_stall_data: got n=%0d want 01 02 03 04", echo_q.size());
      end
      // Operand path stall.
      opnd_ready_i = 1'b0;
      tx_q = '{8'ha0, 8'h00, 8'h08, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40};
      fork
         send_tx();
         begin
            n = 0;
            @(negedge clk_i);
            while (!opnd_valid_o && n < 100) begin n++; @(negedge clk_i); end
            stall_ok = opnd_valid_o;
            for (int i = 0; i < 5; i++) begin
               if (rx_ready_o !== 1'b0) stall_ok = 1'b0;
               @(negedge clk_i);
            end
            vectors++;
            if (!stall_ok) begin miscompares++; $display("FAIL opnd_stall: rx_ready not held low (or no operand), want low"); end
            @(posedge clk_i);
            #1;
            opnd_ready_i = 1'b1;
         end
      join
      settle();
      vectors++;
      if (opnd_q.size() !== 2 || opnd_q[0] !== {2'b10, 32'h04030201} || opnd_q[1] !== {2'b01, 32'h40302010}) begin
         miscompares++; $display("FAIL opnd_stall_data: got n=%0d w0=%h want 2 words 2_04030201 1_40302010", opnd_q.size(), opnd_q[0]);
      end
   endtask

   task automatic test_reset_mid();
      tx_q = '{8'ha0, 8'h00, 8'h08, 8'h00, 8'h01, 8'h02};
      send_tx();
      rst_i = 1'b1;
      @(negedge clk_i);
      vectors++;
      if ({opcode_o, len_o, rx_ready_o} !== 25'h0) begin
         miscompares++; $display("FAIL midrst_outputs: got %h/%h/%b want 0", opcode_o, len_o, rx_ready_o);
      end
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      clear_obs();
      tx_q = '{8'hec, 8'h00, 8'h01, 8'h00, 8'h33};
      send_tx();
      settle();
      vectors += 3;
      if (echo_q.size() !== 1 || echo_q[0] !== 8'h33) begin
         miscompares++; $display("FAIL midrst_echo: got n=%0d first=%h want n=1 33", echo_q.size(), echo_q[0]);
      end
      if (opnd_q.size() !== 0) begin miscompares++; $display("FAIL midrst_no_opnd: got %0d want 0", opnd_q.size()); end
      if (hdr_cnt !== 1 || last_op !== 8'hec) begin
         miscompares++; $display("FAIL midrst_hdr: got n=%0d op=%h want 1 ec", hdr_cnt, last_op);
      end
   endtask

   initial begin
      rst_i        = 1'b1;
      rx_data_i    = '0;
      rx_valid_i   = 1'b0;
      echo_ready_i = 1'b1;
      opnd_ready_i = 1'b1;
      echo_hold    = 1'b0;
      opnd_hold    = 1'b0;
      clear_obs();
      test_reset();
      test_echo();
      test_add();
      test_mul_partial();
      test_err_drop();
      test_zero_len();
      test_stall();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
